// File: rtl/sram_to_sram_read.sv
// rtl/sram_to_sram_read.sv - lockstep two-SRAM address sweep presented as a credit-limited output stream
//
// Ports:
//   clk, reset_n (async, active low), cke (global clock enable, shared with the SRAMs)
//   start          : begin a sweep (sampled in IDLE only)
//   busy, done     : sweep in progress / one-cycle completion pulse
//   mem0_*, mem1_* : SRAM read ports (ren, raddr out; rdata in, MEM_LATENCY cycles after ren)
//   m_data0/1, m_valid, m_ready : output stream, one word pair per address
//   m_last         : present only with SRAM_TO_SRAM_READ_LAST_EN; marks the final address beat
//
// Optional build macro: SRAM_TO_SRAM_READ_LAST_EN
module sram_to_sram_read #(
    parameter int ADDR_BITS   = 10,
    parameter int DATA_BITS   = 64,
    parameter int MEM_LATENCY = 1,
    parameter int FIFO_DEPTH  = MEM_LATENCY + 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cke,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mem0_ren,
    output logic [ADDR_BITS-1:0] mem0_raddr,
    input  logic [DATA_BITS-1:0] mem0_rdata,
    output logic                 mem1_ren,
    output logic [ADDR_BITS-1:0] mem1_raddr,
    input  logic [DATA_BITS-1:0] mem1_rdata,
    output logic [DATA_BITS-1:0] m_data0,
    output logic [DATA_BITS-1:0] m_data1,
    output logic                 m_valid,
    input  logic                 m_ready
`ifdef SRAM_TO_SRAM_READ_LAST_EN
    ,
    output logic                 m_last
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   addr;
    logic [CW-1:0]          credits;
    logic [CW-1:0]          credits_next;
    logic [CW-1:0]          count;
    logic [MEM_LATENCY-1:0] vld;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [DATA_BITS-1:0]   fifo0 [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   fifo1 [FIFO_DEPTH];
    logic                   issue;
    logic                   push;
    logic                   pop;

`ifdef SRAM_TO_SRAM_READ_LAST_EN
    logic [MEM_LATENCY-1:0] lst;
    logic                   fifo_last [FIFO_DEPTH];
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both reads still in the SRAM pipeline and words parked in
    // the FIFO, so an issued read always has a FIFO slot waiting for it.
    assign issue   = (state == RUN) && (credits < CW'(FIFO_DEPTH));
    assign push    = vld[MEM_LATENCY-1];
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;

    assign mem0_ren   = issue;
    assign mem1_ren   = issue;
    assign mem0_raddr = addr;
    assign mem1_raddr = addr;

    assign m_data0 = fifo0[rd_ptr];
    assign m_data1 = fifo1[rd_ptr];
`ifdef SRAM_TO_SRAM_READ_LAST_EN
    assign m_last  = m_valid && fifo_last[rd_ptr];
`endif

    always_comb begin
        credits_next = credits;
        if (issue && !pop) begin
            credits_next = credits + CW'(1);
        end else if (!issue && pop) begin
            credits_next = credits - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr    <= '0;
            credits <= '0;
            count   <= '0;
            vld     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SRAM_TO_SRAM_READ_LAST_EN
            lst     <= '0;
`endif
        end else if (cke) begin
            done    <= 1'b0;
            credits <= credits_next;
            // Bit k high means the read issued k+1 cycles ago lands on rdata now.
            vld     <= (vld << 1) | MEM_LATENCY'(issue);
`ifdef SRAM_TO_SRAM_READ_LAST_EN
            lst     <= (lst << 1) | MEM_LATENCY'(issue && (addr == '1));
`endif
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            case (state)
                IDLE: begin
                    // done is still high in the cycle IDLE is re-entered; a start
                    // there is deliberately ignored.
                    if (start && !done) begin
                        state <= RUN;
                        addr  <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr <= addr + ADDR_BITS'(1);
                        if (addr == '1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Zero credits next cycle means the final word pops now, so
                    // done lands in the cycle right after the last beat.
                    if (credits_next == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (cke && push) begin
            fifo0[wr_ptr] <= mem0_rdata;
            fifo1[wr_ptr] <= mem1_rdata;
`ifdef SRAM_TO_SRAM_READ_LAST_EN
            fifo_last[wr_ptr] <= lst[MEM_LATENCY-1];
`endif
        end
    end

endmodule

// File: tb/tb_sram_to_sram_read.sv
// tb/tb_sram_to_sram_read.sv - bench for sram_to_sram_read at read latencies 1 and 3
module tb_sram_to_sram_read;

    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int NW  = 16;
    localparam int FD0 = 3;
    localparam int FD1 = 5;

    logic clk;
    logic reset_n;
    logic cke;
    logic start;
    logic m_ready;

    logic          ren0   [2];
    logic          ren1   [2];
    logic [AW-1:0] raddr0 [2];
    logic [AW-1:0] raddr1 [2];
    logic [DW-1:0] rd0    [2];
    logic [DW-1:0] rd1    [2];
    logic [DW-1:0] d0     [2];
    logic [DW-1:0] d1     [2];
    logic          valid  [2];
    logic          busy   [2];
    logic          done   [2];
`ifdef SRAM_TO_SRAM_READ_LAST_EN
    logic          last   [2];
`endif

    sram_to_sram_read #(.ADDR_BITS(AW), .DATA_BITS(DW), .MEM_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .cke(cke), .start(start),
        .busy(busy[0]), .done(done[0]),
        .mem0_ren(ren0[0]), .mem0_raddr(raddr0[0]), .mem0_rdata(rd0[0]),
        .mem1_ren(ren1[0]), .mem1_raddr(raddr1[0]), .mem1_rdata(rd1[0]),
        .m_data0(d0[0]), .m_data1(d1[0]), .m_valid(valid[0]), .m_ready(m_ready)
`ifdef SRAM_TO_SRAM_READ_LAST_EN
        , .m_last(last[0])
`endif
    );

    sram_to_sram_read #(.ADDR_BITS(AW), .DATA_BITS(DW), .MEM_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset_n(reset_n), .cke(cke), .start(start),
        .busy(busy[1]), .done(done[1]),
        .mem0_ren(ren0[1]), .mem0_raddr(raddr0[1]), .mem0_rdata(rd0[1]),
        .mem1_ren(ren1[1]), .mem1_raddr(raddr1[1]), .mem1_rdata(rd1[1]),
        .m_data0(d0[1]), .m_data1(d1[1]), .m_valid(valid[1]), .m_ready(m_ready)
`ifdef SRAM_TO_SRAM_READ_LAST_EN
        , .m_last(last[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM contents and per-instance read pipelines (shared cke, garbage when not read)
    logic [DW-1:0] m0 [NW];
    logic [DW-1:0] m1 [NW];
    logic [DW-1:0] pa [2][4];
    logic [DW-1:0] pb [2][4];

    always @(posedge clk) begin
        if (cke) begin
            for (int i = 0; i < 2; i++) begin
                for (int s = 3; s > 0; s--) begin
                    pa[i][s] <= pa[i][s-1];
                    pb[i][s] <= pb[i][s-1];
                end
                pa[i][0] <= ren0[i] ? m0[raddr0[i]] : DW'($urandom);
                pb[i][0] <= ren1[i] ? m1[raddr1[i]] : DW'($urandom);
            end
        end
    end

    assign rd0[0] = pa[0][0];
    assign rd1[0] = pb[0][0];
    assign rd0[1] = pa[1][2];
    assign rd1[1] = pb[1][2];

    int total;
    int bad;
    int cyc;

    // reference model state, per instance
    bit            exp_busy    [2];
    bit            exp_done    [2];
    bit            hold        [2];
    logic [31:0]   held        [2];
    logic [39:0]   prev_v      [2];
    bit            prev_cke;
    int            next_issue  [2];
    int            issued      [2];
    int            popped      [2];
    int            beat_idx    [2];
    int            sweep_beats [2];
    int            dones       [2];
    int            peak        [2];
    int            first_issue [2];
    int            first_valid [2];
    int            last_beat   [2];

    typedef struct {
        string name;
        int    mode;       // 0 ready=1, 1 ready 1,0,0,1, 2 ready=0 for 20 cycles, 3 random
        int    cke_at;     // cycle of a 5-cycle cke-low gap, 0 = none
        bit    rand_data;
        int    exp_beats;
        int    exp_dones;
    } vec_t;

    vec_t vecs [6];

    function automatic int fd(input int i);
        return (i == 0) ? FD0 : FD1;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h (cycle %0d)", nm, inst, act, exp, cyc);
        end
    endtask

    task automatic chk_le(input string nm, input int inst, input int act, input int lim);
        total++;
        if (act > lim) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0d limit=%0d (cycle %0d)", nm, inst, act, lim, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_busy[i]   = 1'b0;
            exp_done[i]   = 1'b0;
            hold[i]       = 1'b0;
            issued[i]     = 0;
            popped[i]     = 0;
            next_issue[i] = 0;
            beat_idx[i]   = 0;
        end
        prev_cke = 1'b1;
    endtask

    task automatic fill(input bit rnd);
        for (int n = 0; n < NW; n++) begin
            m0[n] = rnd ? DW'($urandom) : DW'(n);
            m1[n] = rnd ? DW'($urandom) : ~DW'(n);
        end
    endtask

    // Called just after a negedge with inputs already driven; samples, checks,
    // advances the reference model, then waits for the next negedge.
    task automatic cycle();
        logic [39:0] v;
        logic        pop;
        logic        iss;
        int          outstanding;
        #1;
        for (int i = 0; i < 2; i++) begin
            v   = {ren0[i], raddr0[i], valid[i], d0[i], d1[i], busy[i], done[i]};
            pop = valid[i] && m_ready && cke;
            iss = ren0[i] && cke;
            if (reset_n) begin
                chk("busy", i, 64'(busy[i]), 64'(exp_busy[i]));
                chk("done", i, 64'(done[i]), 64'(exp_done[i]));
                chk("ren_outside_sweep", i, 64'(ren0[i] && !exp_busy[i]), 64'(0));
                chk("mem1_lockstep", i, 64'({ren1[i], raddr1[i]}), 64'({ren0[i], raddr0[i]}));
                if (ren0[i]) chk("raddr", i, 64'(raddr0[i]), 64'(next_issue[i] & 15));
                if (!prev_cke) chk("cke_freeze", i, 64'(v), 64'(prev_v[i]));
                if (hold[i]) begin
                    chk("stall_valid", i, 64'(valid[i]), 64'(1));
                    chk("stall_data", i, 64'({d0[i], d1[i]}), 64'(held[i]));
                end
                if (valid[i] && first_valid[i] < 0) first_valid[i] = cyc;
                if (iss && first_issue[i] < 0) first_issue[i] = cyc;
                if (pop) begin
                    chk("data0", i, 64'(d0[i]), 64'(m0[beat_idx[i] & 15]));
                    chk("data1", i, 64'(d1[i]), 64'(m1[beat_idx[i] & 15]));
`ifdef SRAM_TO_SRAM_READ_LAST_EN
                    chk("last", i, 64'(last[i]), 64'(beat_idx[i] == NW - 1));
`endif
                    beat_idx[i]++;
                    sweep_beats[i]++;
                    popped[i]++;
                    last_beat[i] = cyc;
                end
                if (iss) begin
                    next_issue[i]++;
                    issued[i]++;
                end
                outstanding = issued[i] - popped[i];
                if (outstanding > peak[i]) peak[i] = outstanding;
                chk_le("credits", i, outstanding, fd(i));
                if (cke) begin
                    if (pop && beat_idx[i] == NW) begin
                        exp_done[i] = 1'b1;
                        exp_busy[i] = 1'b0;
                        dones[i]++;
                    end else begin
                        if (!exp_busy[i] && start && !exp_done[i]) begin
                            exp_busy[i]   = 1'b1;
                            next_issue[i] = 0;
                            beat_idx[i]   = 0;
                            issued[i]     = 0;
                            popped[i]     = 0;
                        end
                        exp_done[i] = 1'b0;
                    end
                end
                hold[i] = valid[i] && !pop;
                held[i] = {d0[i], d1[i]};
            end
            prev_v[i] = v;
        end
        prev_cke = cke;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_sweep(input int mode, input int cke_at, input int abort_n, input bit start_on_done);
        bit finished;
        finished = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sweep_beats[i] = 0;
            dones[i]       = 0;
            peak[i]        = 0;
            first_issue[i] = -1;
            first_valid[i] = -1;
            last_beat[i]   = -1;
        end
        for (int k = 0; k < 800; k++) begin
            if (mode == 2 && k == 20) begin
                for (int i = 0; i < 2; i++) begin
                    chk("stall_issue_count", i, 64'(issued[i]), 64'(fd(i)));
                    chk("stall_ren_low", i, 64'(ren0[i]), 64'(0));
                end
            end
            start = (k == 0)
                 || (start_on_done && exp_done[0])
                 || (mode == 3 && exp_busy[0] && exp_busy[1] && $urandom_range(0, 7) == 0);
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
                2:       m_ready = (k >= 20);
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            cke = !(cke_at != 0 && k >= cke_at && k < cke_at + 5);
            cycle();
            if (abort_n > 0 && sweep_beats[0] >= abort_n) begin
                finished = 1'b1;
                break;
            end
            if (dones[0] >= 1 && dones[1] >= 1) begin
                finished = 1'b1;
                break;
            end
        end
        chk("sweep_within_budget", 0, 64'(finished), 64'(1));
        start   = 1'b0;
        cke     = 1'b1;
        m_ready = 1'b1;
        if (abort_n <= 0) repeat (2) cycle();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        reset_n = 1'b0;
        cke     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b1;

        vecs[0] = '{"ramp_ready_high", 0, 0, 1'b0, 16, 1};
        vecs[1] = '{"ready_1001",      1, 0, 1'b0, 16, 1};
        vecs[2] = '{"ready_low_20",    2, 0, 1'b1, 16, 1};
        vecs[3] = '{"cke_gap",         0, 6, 1'b0, 16, 1};
        vecs[4] = '{"random_a",        3, 0, 1'b1, 16, 1};
        vecs[5] = '{"random_cke",      3, 9, 1'b1, 16, 1};

        fill(1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy",  i, 64'(busy[i]),   64'(0));
            chk("reset_done",  i, 64'(done[i]),   64'(0));
            chk("reset_ren",   i, 64'({ren0[i], ren1[i]}), 64'(0));
            chk("reset_raddr", i, 64'({raddr0[i], raddr1[i]}), 64'(0));
            chk("reset_valid", i, 64'(valid[i]),  64'(0));
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cycle();

        foreach (vecs[n]) begin
            fill(vecs[n].rand_data);
            run_sweep(vecs[n].mode, vecs[n].cke_at, 0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                chk({vecs[n].name, "_beats"}, i, 64'(sweep_beats[i]), 64'(vecs[n].exp_beats));
                chk({vecs[n].name, "_dones"}, i, 64'(dones[i]), 64'(vecs[n].exp_dones));
                chk({vecs[n].name, "_idle_raddr"}, i, 64'(raddr0[i]), 64'(0));
                chk_le({vecs[n].name, "_peak"}, i, peak[i], fd(i));
                if (vecs[n].mode == 0 && vecs[n].cke_at == 0) begin
                    chk("first_latency", i, 64'(first_valid[i] - first_issue[i]), 64'(lat(i) + 1));
                    chk("back_to_back", i, 64'(last_beat[i] - first_valid[i]), 64'(NW - 1));
                end
                if (vecs[n].mode == 1) chk("peak_credits", i, 64'(peak[i]), 64'(fd(i)));
            end
        end

        // start held high in the done cycle must not launch a sweep
        fill(1'b1);
        run_sweep(0, 0, 0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("done_cycle_beats", i, 64'(sweep_beats[i]), 64'(NW));
            chk("done_cycle_dones", i, 64'(dones[i]), 64'(1));
        end

        // reset mid-sweep after beat 7 of the latency-1 instance
        fill(1'b0);
        run_sweep(0, 0, 8, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("abort_async_outputs", i,
                64'({busy[i], done[i], ren0[i], ren1[i], raddr0[i], raddr1[i], valid[i]}), 64'(0));
`ifdef SRAM_TO_SRAM_READ_LAST_EN
            chk("abort_async_last", i, 64'(last[i]), 64'(0));
`endif
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) cycle();
        for (int i = 0; i < 2; i++) chk("abort_no_done", i, 64'(dones[i]), 64'(0));
        run_sweep(0, 0, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("after_abort_beats", i, 64'(sweep_beats[i]), 64'(NW));
            chk("after_abort_dones", i, 64'(dones[i]), 64'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
